// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv layer address controller and the
// accumulator/writer. Holds default widths, per-layer output counts, the tap
// flag bundle and the ReLU/saturation helpers.
package conv_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int WEIGHT_W_DEF = 8;
    localparam int BIAS_W_DEF   = 16;
    localparam int ACC_W_DEF    = 24;
    localparam int OUT_W_DEF    = 8;

    // Layer 1 output map: 28 x 28 x 1
    localparam int L1_OUT_COUNT  = 784;
    localparam int L1_W_OUT_ADDR = 10;

    // Working width for the clamp helpers; must exceed ACC_W + 1.
    localparam int SAT_W = 40;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tap_flags_t;

    function automatic logic signed [SAT_W-1:0] out_max(input int out_w);
        return signed'((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
    endfunction

    // ReLU followed by clamp to the largest positive out_w-bit value.
    function automatic logic signed [SAT_W-1:0] relu_sat(input logic signed [SAT_W-1:0] s,
                                                         input int out_w);
        logic signed [SAT_W-1:0] hi;
        hi = out_max(out_w);
        if (s < 0)
            return '0;
        else if (s > hi)
            return hi;
        else
            return s;
    endfunction

endpackage

// File: rtl/conv_accum_writer_if.sv
// conv_accum_writer_if: tap stream (flags + SRAM read data) into the writer
// and the output feature-map write bus out of it.
//   master : drives the tap stream, observes the write bus (controller/SRAM side)
//   slave  : consumes the tap stream, drives the write bus (conv_accum_writer)
interface conv_accum_writer_if
    import conv_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WEIGHT_W   = WEIGHT_W_DEF,
    parameter int BIAS_W     = BIAS_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int W_OUT_ADDR = L1_W_OUT_ADDR
);
    logic                       valid_in;
    logic                       first_in;
    logic                       last_in;
    logic signed [DATA_W-1:0]   rd_data;
    logic signed [WEIGHT_W-1:0] rd_weight;
    logic signed [BIAS_W-1:0]   rd_bias;

    logic                       wr_en;
    logic [W_OUT_ADDR-1:0]      wr_addr;
    logic signed [OUT_W-1:0]    wr_data;

    modport master (
        output valid_in, first_in, last_in, rd_data, rd_weight, rd_bias,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  valid_in, first_in, last_in, rd_data, rd_weight, rd_bias,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pipe_delay.sv
// pipe_delay: DEPTH-stage shift register (DEPTH >= 1) with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : clears every stage on the next edge
//   din, dout  : WIDTH-bit input and DEPTH-cycle delayed output
module pipe_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/conv_accum_writer.sv
// conv_accum_writer: per-window multiply-accumulate, bias add, arithmetic
// shift, ReLU and saturation; writes one output pixel per window.
//   clk, rst_n : clock, async active-low reset
//   go         : start/restart; flushes in-flight windows, clears counter and sat_flag
//   bus        : slave side of conv_accum_writer_if (tap stream in, write bus out)
//   busy       : map in progress, drops the cycle after the final write
//   done       : one-cycle pulse together with the final write of the map
//   sat_flag   : sticky, an upper clamp happened since the last go
module conv_accum_writer
    import conv_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WEIGHT_W     = WEIGHT_W_DEF,
    parameter int BIAS_W       = BIAS_W_DEF,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int QSHIFT       = 4,
    parameter int READ_LATENCY = 1,
    parameter int OUT_COUNT    = L1_OUT_COUNT,
    parameter int W_OUT_ADDR   = L1_W_OUT_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    conv_accum_writer_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam logic [W_OUT_ADDR-1:0] LAST_ADDR = W_OUT_ADDR'(OUT_COUNT - 1);

    // Flag alignment: flags travel READ_LATENCY cycles to meet rd_* data.
    tap_flags_t flags_a;
    tap_flags_t flags_d;

    assign flags_a = '{valid: bus.valid_in,
                       first: bus.first_in,
                       last:  bus.last_in & bus.valid_in};

    pipe_delay #(
        .DEPTH (READ_LATENCY),
        .WIDTH ($bits(tap_flags_t))
    ) u_flag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .din   (flags_a),
        .dout  (flags_d)
    );

    // Stage 1: product and flags
    logic                     v1, f1, l1;
    logic signed [PROD_W-1:0] prod1;
    logic signed [BIAS_W-1:0] bias1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            f1    <= 1'b0;
            l1    <= 1'b0;
            prod1 <= '0;
            bias1 <= '0;
        end else begin
            v1    <= flags_d.valid & ~go;
            f1    <= flags_d.first & ~go;
            l1    <= flags_d.last  & ~go;
            prod1 <= PROD_W'(bus.rd_data) * PROD_W'(bus.rd_weight);
            bias1 <= bus.rd_bias;
        end
    end

    // Stage 2: accumulate; idle cycles inside a window simply hold acc
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic                     emit2;
    logic signed [BIAS_W-1:0] bias2;

    assign prod_ext = {{(ACC_W-PROD_W){prod1[PROD_W-1]}}, prod1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            emit2 <= 1'b0;
            bias2 <= '0;
        end else begin
            if (v1) acc <= f1 ? prod_ext : acc + prod_ext;
            emit2 <= v1 & l1 & ~go;
            bias2 <= bias1;
        end
    end

    // Stage 3 datapath: one guard bit so acc + bias cannot wrap before the shift
    logic signed [ACC_W:0]   bias_ext;
    logic signed [ACC_W:0]   sum_s;
    logic signed [ACC_W:0]   shifted;
    logic signed [SAT_W-1:0] sat_in;
    logic signed [SAT_W-1:0] clamped;
    logic                    over;

    assign bias_ext = {{(ACC_W+1-BIAS_W){bias2[BIAS_W-1]}}, bias2};
    assign sum_s    = {acc[ACC_W-1], acc} + bias_ext;
    assign shifted  = sum_s >>> QSHIFT;
    assign sat_in   = {{(SAT_W-ACC_W-1){shifted[ACC_W]}}, shifted};
    assign clamped  = relu_sat(sat_in, OUT_W);
    assign over     = sat_in > out_max(OUT_W);

    // Stage 3 registers, address counter and map status
    logic [W_OUT_ADDR-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sat_flag    <= 1'b0;
        end else if (go) begin
            bus.wr_en <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            bus.wr_en <= emit2;
            done      <= 1'b0;
            // done marks the final write; busy follows one cycle later
            if (done) busy <= 1'b0;
            if (emit2) begin
                bus.wr_addr <= cnt;
                bus.wr_data <= clamped[OUT_W-1:0];
                if (over) sat_flag <= 1'b1;
                if (cnt == LAST_ADDR) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + W_OUT_ADDR'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_accum_writer.sv
module tb_conv_accum_writer;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int BW = 16;
    localparam int AW = 24;
    localparam int OW = 8;
    localparam int QS = 4;
    localparam int RL = 1;
    localparam int OC = 4;
    localparam int AD = 10;

    logic clk;
    logic rst_n;
    logic go;
    logic busy, done, sat_flag;

    conv_accum_writer_if #(
        .DATA_W(DW), .WEIGHT_W(WW), .BIAS_W(BW), .OUT_W(OW), .W_OUT_ADDR(AD)
    ) bus ();

    conv_accum_writer #(
        .DATA_W(DW), .WEIGHT_W(WW), .BIAS_W(BW), .ACC_W(AW), .OUT_W(OW),
        .QSHIFT(QS), .READ_LATENCY(RL), .OUT_COUNT(OC), .W_OUT_ADDR(AD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .sat_flag (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit sat;
        bit last_of_map;
        int cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     go_vis = -1;
    bit     mon_en = 0;
    bit     busy_m = 0;
    bit     sat_m = 0;
    bit     prev_done = 0;

    // reference model state
    longint m_acc = 0;
    int     m_cnt = 0;
    int     dly_d[RL];
    int     dly_w[RL];
    int     dly_b[RL];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rnd8();
        logic signed [7:0] x;
        x = 8'($urandom);
        return int'(x);
    endfunction

    function automatic int rnd_bias();
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // One address cycle. d/w/b belong to the tap addressed now and reach the
    // DUT RL cycles later.
    task automatic drive(input bit g, input bit v, input bit f, input bit l,
                         input int d, input int w, input int b);
        longint s;
        exp_t   e;
        @(negedge clk);
        go           = g;
        bus.valid_in = v;
        bus.first_in = f;
        bus.last_in  = l;
        bus.rd_data   = DW'(dly_d[RL-1]);
        bus.rd_weight = WW'(dly_w[RL-1]);
        bus.rd_bias   = BW'(dly_b[RL-1]);
        for (int i = RL - 1; i > 0; i--) begin
            dly_d[i] = dly_d[i-1];
            dly_w[i] = dly_w[i-1];
            dly_b[i] = dly_b[i-1];
        end
        dly_d[0] = d;
        dly_w[0] = w;
        dly_b[0] = b;
        if (g) begin
            // anything not yet on the bus by the go edge is discarded
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            m_cnt  = 0;
            go_vis = cyc + 1;
        end else if (v) begin
            if (f) m_acc = longint'(d) * longint'(w);
            else   m_acc = m_acc + longint'(d) * longint'(w);
            if (l) begin
                s = (m_acc + longint'(b)) >>> QS;
                e.sat = 0;
                if (s < 0) e.data = 0;
                else if (s > 127) begin
                    e.data = 127;
                    e.sat  = 1;
                end else e.data = int'(s);
                e.addr        = m_cnt;
                e.last_of_map = (m_cnt == OC - 1);
                e.cyc         = cyc + RL + 3;
                exp_q.push_back(e);
                m_cnt = (m_cnt + 1) % OC;
            end
        end
    endtask

    task automatic tap(input bit f, input bit l, input int d, input int w, input int b);
        drive(0, 1, f, l, d, w, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 1'($urandom), 1'($urandom), rnd8(), rnd8(), rnd_bias());
    endtask

    task automatic start();
        drive(1, 0, 0, 0, rnd8(), rnd8(), rnd_bias());
    endtask

    task automatic rand_window(input int ntaps, input bit gaps);
        for (int i = 0; i < ntaps; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            tap(i == 0, i == ntaps - 1, rnd8(), rnd8(), rnd_bias());
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (prev_done) busy_m = 0;
            if (cyc == go_vis) begin
                busy_m = 1;
                sat_m  = 0;
            end
            if (mon_en) begin
                chk("busy", busy, busy_m);
                if (bus.wr_en) begin
                    if (exp_q.size() == 0) chk("spurious_wr", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        sat_m = sat_m | e.sat;
                        chk("wr_cycle", cyc, e.cyc);
                        chk("wr_addr", bus.wr_addr, e.addr);
                        chk("wr_data", bus.wr_data, e.data);
                        chk("sat_flag", sat_flag, sat_m);
                        chk("done", done, e.last_of_map);
                    end
                end else begin
                    chk("done_idle", done, 0);
                    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                        chk("missing_wr", 0, 1);
                        void'(exp_q.pop_front());
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin
        int gd[4];
        int gw[4];
        for (int i = 0; i < RL; i++) begin
            dly_d[i] = 0;
            dly_w[i] = 0;
            dly_b[i] = 0;
        end
        rst_n         = 1'b0;
        go            = 1'b0;
        bus.valid_in  = 1'b0;
        bus.first_in  = 1'b0;
        bus.last_in   = 1'b0;
        bus.rd_data   = '0;
        bus.rd_weight = '0;
        bus.rd_bias   = '0;
        #23;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat_flag, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        // directed map: 1x1 (->1), 3x3 (90>>>4=5), negative (->0), 4000 (->127, sat)
        start();
        idle(2);
        tap(1, 1, 5, 3, 16);
        idle(5);
        for (int i = 0; i < 9; i++) tap(i == 0, i == 8, 2, i + 1, 0);
        idle(5);
        tap(1, 1, -10, 10, 0);
        idle(5);
        tap(1, 1, 100, 40, 0);
        idle(8);

        // same window gapless then with a 3-cycle hole, then two back-to-back
        start();
        idle(1);
        for (int i = 0; i < 4; i++) begin
            gd[i] = rnd8();
            gw[i] = rnd8();
        end
        for (int i = 0; i < 4; i++) tap(i == 0, i == 3, gd[i], gw[i], 300);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) idle(3);
            tap(i == 0, i == 3, gd[i], gw[i], 300);
        end
        rand_window(4, 0);
        rand_window(4, 0);
        idle(8);

        // go in the middle of a window: partial window must never be written
        start();
        idle(2);
        rand_window(2, 0);
        idle(6);
        tap(1, 0, rnd8(), rnd8(), rnd_bias());
        tap(0, 0, rnd8(), rnd8(), rnd_bias());
        tap(0, 0, rnd8(), rnd8(), rnd_bias());
        start();
        for (int i = 0; i < OC; i++) rand_window(4, 0);
        idle(8);

        // go while writes are still in the pipeline
        start();
        rand_window(3, 0);
        rand_window(1, 0);
        idle(1);
        start();
        for (int i = 0; i < OC; i++) rand_window($urandom_range(1, 9), 1);
        idle(8);

        // random maps
        for (int m = 0; m < 20; m++) begin
            start();
            idle($urandom_range(0, 2));
            for (int i = 0; i < OC; i++) rand_window($urandom_range(1, 9), 1'($urandom));
            idle(8);
        end

        idle(10);
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
